// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
//
// Round-robin arbiter that shares one 4:1 data multiplexer between four
// requesters. A granted requester's word is presented on a single valid/ready
// output channel, and each accepted transfer is acknowledged with a one-cycle
// pulse on ack.
//
// Optional feature macro: MUXARB_BURST_EN
//   defined   - a requester holding lock may keep the grant for up to
//               MAX_BURST consecutive beats.
//   undefined - lock is ignored; every transfer rotates the grant.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   req        request per requester (bit k = requester k)
//   in_data    requester k data at [k*W +: W]
//   lock       burst-hold request per requester
//   out_valid  selected word valid (never set in IDLE)
//   out_ready  consumer accepts the word this cycle
//   out_data   data of the selected requester
//   sel        multiplexer select (granted index)
//   gnt        one-hot grant, zero in IDLE
//   ack        one-hot, one-cycle transfer acknowledge
module mux4_rr_arbiter #(
  parameter int unsigned W         = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     req,
  input  logic [4*W-1:0] in_data,
  input  logic [3:0]     lock,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [1:0]     sel,
  output logic [3:0]     gnt,
  output logic [3:0]     ack
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] sel_oh;
  logic [2:0] pick;
  logic       xfer;

  logic [W-1:0] slices [4];

  for (genvar k = 0; k < 4; k++) begin : g_slice
    assign slices[k] = in_data[k*W +: W];
  end

  // Returns {found, index}: first set bit of r searching p+1, p+2, p+3, p.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 1; i <= 4; i++) begin
      idx = p + 2'(i);
      if (r[idx] && !res[2]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  assign sel_oh   = 4'b0001 << sel_q;
  assign sel      = sel_q;
  assign out_data = slices[sel_q];

`ifdef MUXARB_BURST_EN
  localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

  logic [3:0] beats_q, beats_d;
  logic       hold;

  // Stay on the current requester while it asks for a burst and has beats left.
  assign hold = lock[sel_q] && req[sel_q] && (beats_q < MaxBurst);

  always_ff @(posedge clk) begin
    if (rst) begin
      beats_q <= 4'd1;
    end else begin
      beats_q <= beats_d;
    end
  end
`else
  logic hold;
  logic unused_lock;

  assign hold        = 1'b0;
  assign unused_lock = ^lock;
`endif

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    pick      = 3'b000;
    out_valid = 1'b0;
    gnt       = 4'b0000;
    ack       = 4'b0000;
    xfer      = 1'b0;
`ifdef MUXARB_BURST_EN
    beats_d   = beats_q;
`endif
    unique case (state_q)
      StIdle: begin
        pick = rr_pick(req, ptr_q);
        if (pick[2]) begin
          sel_d   = pick[1:0];
          state_d = StGrant;
`ifdef MUXARB_BURST_EN
          beats_d = 4'd1;
`endif
        end
      end
      StGrant: begin
        gnt       = sel_oh;
        out_valid = req[sel_q];
        // Reset wins over a transfer in the same cycle.
        xfer      = out_valid && out_ready && !rst;
        if (xfer) begin
          ack = sel_oh;
          if (hold) begin
`ifdef MUXARB_BURST_EN
            beats_d = beats_q + 4'd1;
`endif
          end else begin
            ptr_d = sel_q;
            // Re-arbitrate from the just-served index, excluding it.
            pick  = rr_pick(req & ~sel_oh, sel_q);
            if (pick[2]) begin
              sel_d = pick[1:0];
`ifdef MUXARB_BURST_EN
              beats_d = 4'd1;
`endif
            end else begin
              state_d = StIdle;
            end
          end
        end else if (!req[sel_q]) begin
          // Request withdrawn without a transfer: drop back, pointer untouched.
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd3;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter.
module tb_mux4_rr_arbiter;

  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     req;
  logic [4*W-1:0] in_data;
  logic [3:0]     lock;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     sel;
  logic [3:0]     gnt;
  logic [3:0]     ack;

  logic [W-1:0] tb_data [4];
  int n_checks = 0;
  int n_fail   = 0;

  mux4_rr_arbiter #(.W(W), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .in_data   (in_data),
    .lock      (lock),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sel       (sel),
    .gnt       (gnt),
    .ack       (ack)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    req  = 4'b0000;
    lock = 4'b0000;
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b0000; lock = 4'b0000; out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL reset_valid cyc %0d: got %b want 0", i, out_valid);
      end
      n_checks++;
      if (gnt !== 4'b0000) begin
        n_fail++; $display("FAIL reset_gnt cyc %0d: got %b want 0000", i, gnt);
      end
      n_checks++;
      if (sel !== 2'd0) begin
        n_fail++; $display("FAIL reset_sel cyc %0d: got %0d want 0", i, sel);
      end
      n_checks++;
      if (ack !== 4'b0000) begin
        n_fail++; $display("FAIL reset_ack cyc %0d: got %b want 0000", i, ack);
      end
      n_checks++;
      if (out_data !== tb_data[0]) begin
        n_fail++; $display("FAIL reset_data cyc %0d: got %h want %h", i, out_data, tb_data[0]);
      end
      step();
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] e;
    logic [3:0] e_oh;
    out_ready = 1'b1;
    req = 4'b1111;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rr_idle_valid: got %b want 0", out_valid);
    end
    step();
    for (int i = 0; i < 8; i++) begin
      e    = 2'(i % 4);
      e_oh = 4'b0001 << e;
      #1;
      n_checks++;
      if (sel !== e) begin
        n_fail++; $display("FAIL rr_sel beat %0d: got %0d want %0d", i, sel, e);
      end
      n_checks++;
      if (gnt !== e_oh || ack !== e_oh || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_gnt_ack beat %0d: got gnt=%b ack=%b v=%b want %b %b 1",
                 i, gnt, ack, out_valid, e_oh, e_oh);
      end
      n_checks++;
      if (out_data !== tb_data[e]) begin
        n_fail++; $display("FAIL rr_data beat %0d: got %h want %h", i, out_data, tb_data[e]);
      end
      step();
    end
    go_idle();
  endtask

  task automatic test_ready_low();
    req = 4'b0101;
    out_ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (sel !== 2'd0 || out_valid !== 1'b1 || ack !== 4'b0000 || gnt !== 4'b0001) begin
        n_fail++;
        $display("FAIL stall cyc %0d: got sel=%0d v=%b ack=%b gnt=%b want 0 1 0000 0001",
                 i, sel, out_valid, ack, gnt);
      end
      n_checks++;
      if (out_data !== tb_data[0]) begin
        n_fail++; $display("FAIL stall_data cyc %0d: got %h want %h", i, out_data, tb_data[0]);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (ack !== 4'b0001) begin
      n_fail++; $display("FAIL stall_release_ack: got %b want 0001", ack);
    end
    step();
    req = 4'b0100;
    #1;
    n_checks++;
    if (sel !== 2'd2 || ack !== 4'b0100) begin
      n_fail++; $display("FAIL stall_next: got sel=%0d ack=%b want 2 0100", sel, ack);
    end
    step();
    go_idle();
  endtask

  task automatic test_single_requester();
    logic [3:0] e;
    req = 4'b0100;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      e = (i % 2 == 1) ? 4'b0100 : 4'b0000;
      #1;
      n_checks++;
      if (ack !== e) begin
        n_fail++; $display("FAIL single_ack cyc %0d: got %b want %b", i, ack, e);
      end
      step();
    end
    // Pointer now at 2, so requester 3 must win next.
    req = 4'b1111;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_idle: got valid %b want 0", out_valid);
    end
    step();
    #1;
    n_checks++;
    if (sel !== 2'd3 || gnt !== 4'b1000) begin
      n_fail++; $display("FAIL single_ptr: got sel=%0d gnt=%b want 3 1000", sel, gnt);
    end
    go_idle();
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b1111;
    out_ready = 1'b1;
    step();
    step();
    #1;
    n_checks++;
    if (sel !== 2'd1 || ack !== 4'b0010) begin
      n_fail++; $display("FAIL mid_pre: got sel=%0d ack=%b want 1 0010", sel, ack);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (ack !== 4'b0000) begin
      n_fail++; $display("FAIL mid_ack: got %b want 0000", ack);
    end
    step();
    rst = 1'b0;
    #1;
    n_checks++;
    if (gnt !== 4'b0000 || out_valid !== 1'b0 || sel !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_idle: got gnt=%b v=%b sel=%0d want 0000 0 0", gnt, out_valid, sel);
    end
    step();
    #1;
    n_checks++;
    if (sel !== 2'd0 || gnt !== 4'b0001) begin
      n_fail++; $display("FAIL mid_first: got sel=%0d gnt=%b want 0 0001", sel, gnt);
    end
    go_idle();
  endtask

  task automatic test_lock();
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b0011;
    lock = 4'b0001;
    out_ready = 1'b1;
    step();
`ifdef MUXARB_BURST_EN
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (sel !== 2'd0 || ack !== 4'b0001) begin
        n_fail++; $display("FAIL burst_beat %0d: got sel=%0d ack=%b want 0 0001", i, sel, ack);
      end
      step();
    end
    #1;
    n_checks++;
    if (sel !== 2'd1 || ack !== 4'b0010) begin
      n_fail++; $display("FAIL burst_rotate: got sel=%0d ack=%b want 1 0010", sel, ack);
    end
`else
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (sel !== 2'(i % 2) || ack !== (4'b0001 << (i % 2))) begin
        n_fail++;
        $display("FAIL lock_ignored beat %0d: got sel=%0d ack=%b want %0d", i, sel, ack, i % 2);
      end
      step();
    end
`endif
    go_idle();
  endtask

  initial begin
    tb_data[0] = 8'hA1;
    tb_data[1] = 8'hB2;
    tb_data[2] = 8'hC3;
    tb_data[3] = 8'hD4;
    in_data = {tb_data[3], tb_data[2], tb_data[1], tb_data[0]};
    rst = 1'b1; req = 4'b0000; lock = 4'b0000; out_ready = 1'b0;
    test_reset();
    test_round_robin();
    test_ready_low();
    test_single_requester();
    test_reset_mid();
    test_lock();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
